// File: rtl/consmax_lut_loader.sv
// ConSmax LUT loader: drains the datapath, streams both FP LUTs,
// then publishes the scale position and re-opens the input path.
module consmax_lut_loader #(
  parameter int LUT_ADDR        = 4,
  parameter int LUT_DATA        = 16,
  parameter int SCALA_POS_WIDTH = 5,
  parameter int BUS_NUM         = 8,
  parameter int PIPE_LAT        = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              cfg_start,
  input  logic                              cfg_abort,
  input  logic signed [SCALA_POS_WIDTH-1:0] cfg_scale_pos,
  input  logic [LUT_DATA-1:0]               cfg_data,
  input  logic                              cfg_data_vld,
  output logic                              cfg_data_rdy,
  output logic                              cfg_busy,
  output logic                              cfg_done,
  output logic                              lut_ready,
  input  logic [BUS_NUM-1:0]                in_vld,
  output logic                              in_rdy,
  output logic [BUS_NUM-1:0]                dp_in_vld,
  output logic [LUT_ADDR:0]                 lut_waddr,
  output logic                              lut_wen,
  output logic [LUT_DATA-1:0]               lut_wdata,
  output logic signed [SCALA_POS_WIDTH-1:0] out_scale_pos,
  output logic                              out_scale_pos_vld
);

  typedef enum logic [2:0] {
    UNCFG,
    DRAIN,
    LOAD,
    SCALE,
    RUN
  } state_t;

  localparam int CW = LUT_ADDR + 1;
  localparam logic [CW-1:0] LAST = '1;
  localparam logic [3:0] DRAIN_INIT = 4'(PIPE_LAT);

  state_t                              state;
  logic [3:0]                          drain_cnt;
  logic [CW-1:0]                       ent_cnt;
  logic signed [SCALA_POS_WIDTH-1:0]   scale_q;
  logic                                hs;

  // Handshakes and lane gating decoded straight from state
  always_comb begin
    in_rdy       = (state == RUN);
    dp_in_vld    = in_rdy ? in_vld : '0;
    cfg_data_rdy = (state == LOAD);
    cfg_busy     = (state == DRAIN) ||
                   (state == LOAD)  ||
                   (state == SCALE);
    hs           = cfg_data_vld & cfg_data_rdy & ~cfg_abort;
  end

  // Drain counter: re-armed by any live lane, else counts down to 0
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      drain_cnt <= '0;
    end else if (|dp_in_vld) begin
      drain_cnt <= DRAIN_INIT;
    end else if (drain_cnt != '0) begin
      drain_cnt <= drain_cnt - 1'b1;
    end
  end

  // Control FSM with registered LUT write port and status outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state             <= UNCFG;
      ent_cnt           <= '0;
      scale_q           <= '0;
      lut_ready         <= 1'b0;
      cfg_done          <= 1'b0;
      lut_wen           <= 1'b0;
      lut_waddr         <= '0;
      lut_wdata         <= '0;
      out_scale_pos     <= '0;
      out_scale_pos_vld <= 1'b0;
    end else begin
      cfg_done          <= 1'b0;
      out_scale_pos_vld <= 1'b0;
      lut_wen           <= hs;
      if (hs) begin
        lut_waddr <= ent_cnt;
        lut_wdata <= cfg_data;
      end
      unique case (state)
        UNCFG: begin
          if (cfg_start) begin
            state   <= DRAIN;
            scale_q <= cfg_scale_pos;
          end
        end
        DRAIN: begin
          if (cfg_abort) begin
            state     <= UNCFG;
            lut_ready <= 1'b0;
          end else if (drain_cnt == '0) begin
            state     <= LOAD;
            ent_cnt   <= '0;
            lut_ready <= 1'b0;
          end
        end
        LOAD: begin
          if (cfg_abort) begin
            state     <= UNCFG;
            lut_ready <= 1'b0;
          end else if (hs) begin
            ent_cnt <= ent_cnt + 1'b1;
            if (ent_cnt == LAST) begin
              state <= SCALE;
            end
          end
        end
        SCALE: begin
          out_scale_pos     <= scale_q;
          out_scale_pos_vld <= 1'b1;
          cfg_done          <= 1'b1;
          lut_ready         <= 1'b1;
          state             <= RUN;
        end
        RUN: begin
          if (cfg_start) begin
            state   <= DRAIN;
            scale_q <= cfg_scale_pos;
          end
        end
        default: begin
          state <= UNCFG;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_consmax_lut_loader.sv
// Directed bench for consmax_lut_loader: load, drain, throttle,
// abort, mid-load reset and ignored restart scenarios.
module tb_consmax_lut_loader;

  localparam int LA = 4;
  localparam int LD = 16;
  localparam int SW = 5;
  localparam int BN = 8;
  localparam int PL = 4;
  localparam int NE = 2 ** (LA + 1);

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 cfg_start;
  logic                 cfg_abort;
  logic signed [SW-1:0] cfg_scale_pos;
  logic [LD-1:0]        cfg_data;
  logic                 cfg_data_vld;
  logic                 cfg_data_rdy;
  logic                 cfg_busy;
  logic                 cfg_done;
  logic                 lut_ready;
  logic [BN-1:0]        in_vld;
  logic                 in_rdy;
  logic [BN-1:0]        dp_in_vld;
  logic [LA:0]          lut_waddr;
  logic                 lut_wen;
  logic [LD-1:0]        lut_wdata;
  logic signed [SW-1:0] out_scale_pos;
  logic                 out_scale_pos_vld;

  int checks = 0;
  int errors = 0;
  int cycle = 0;

  logic [LA:0]          wa[$];
  logic [LD-1:0]        wd[$];
  int                   wc[$];
  int                   n_svld;
  int                   n_done;
  logic signed [SW-1:0] svld_val;
  bit                   aborted;

  consmax_lut_loader #(
    .LUT_ADDR(LA),
    .LUT_DATA(LD),
    .SCALA_POS_WIDTH(SW),
    .BUS_NUM(BN),
    .PIPE_LAT(PL)
  ) dut (
    .clk(clk),
    .rst(rst),
    .cfg_start(cfg_start),
    .cfg_abort(cfg_abort),
    .cfg_scale_pos(cfg_scale_pos),
    .cfg_data(cfg_data),
    .cfg_data_vld(cfg_data_vld),
    .cfg_data_rdy(cfg_data_rdy),
    .cfg_busy(cfg_busy),
    .cfg_done(cfg_done),
    .lut_ready(lut_ready),
    .in_vld(in_vld),
    .in_rdy(in_rdy),
    .dp_in_vld(dp_in_vld),
    .lut_waddr(lut_waddr),
    .lut_wen(lut_wen),
    .lut_wdata(lut_wdata),
    .out_scale_pos(out_scale_pos),
    .out_scale_pos_vld(out_scale_pos_vld)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cycle <= cycle + 1;

  // Source of 0x3F80+k beats; records writes, scale strobes and done pulses.
  task automatic stream(input bit send_start,
                        input logic signed [SW-1:0] scale,
                        input bit toggle,
                        input int abort_at,
                        input int start_at,
                        input logic signed [SW-1:0] alt_scale,
                        input int stop_at,
                        input int max_cyc);
    int k = 0;
    int post = 0;
    bit fired = 0;
    wa.delete();
    wd.delete();
    wc.delete();
    n_svld = 0;
    n_done = 0;
    svld_val = '0;
    aborted = 0;
    for (int c = 0; c < max_cyc; c++) begin
      @(posedge clk);
      #1;
      cfg_start = 1'b0;
      cfg_abort = 1'b0;
      if (c == 0 && send_start) begin
        cfg_start = 1'b1;
        cfg_scale_pos = scale;
      end
      cfg_data = 16'h3F80 + 16'(k);
      cfg_data_vld = (k < stop_at) && (!toggle || (c % 2 == 0));
      if (!fired && k == start_at && cfg_data_rdy) begin
        fired = 1;
        cfg_start = 1'b1;
        cfg_scale_pos = alt_scale;
      end
      if (k == abort_at && cfg_data_vld && cfg_data_rdy) begin
        cfg_abort = 1'b1;
        aborted = 1;
      end
      @(negedge clk);
      if (lut_wen) begin
        wa.push_back(lut_waddr);
        wd.push_back(lut_wdata);
        wc.push_back(cycle);
      end
      if (out_scale_pos_vld) begin
        n_svld++;
        svld_val = out_scale_pos;
      end
      if (cfg_done) n_done++;
      if (cfg_data_vld && cfg_data_rdy && !cfg_abort) k++;
      if (n_done > 0 || aborted) post++;
      if (post > 3) break;
    end
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    cfg_data_vld = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    in_vld = 8'hFF;
    @(negedge clk);
    checks += 9;
    if (cfg_busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %0b want 0", cfg_busy); end
    if (lut_ready !== 1'b0) begin errors++; $display("FAIL rst_ready: got %0b want 0", lut_ready); end
    if (cfg_done !== 1'b0) begin errors++; $display("FAIL rst_done: got %0b want 0", cfg_done); end
    if (lut_wen !== 1'b0) begin errors++; $display("FAIL rst_wen: got %0b want 0", lut_wen); end
    if (lut_waddr !== '0) begin errors++; $display("FAIL rst_waddr: got %0h want 0", lut_waddr); end
    if (lut_wdata !== '0) begin errors++; $display("FAIL rst_wdata: got %0h want 0", lut_wdata); end
    if (out_scale_pos_vld !== 1'b0) begin errors++; $display("FAIL rst_svld: got %0b want 0", out_scale_pos_vld); end
    if (in_rdy !== 1'b0) begin errors++; $display("FAIL rst_in_rdy: got %0b want 0", in_rdy); end
    if (dp_in_vld !== 8'h00) begin errors++; $display("FAIL rst_dp_vld: got %0h want 0", dp_in_vld); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    in_vld = '0;
  endtask

  task automatic test_load();
    stream(1'b1, -5'sd3, 1'b0, -1, -1, 5'sd0, NE, 200);
    checks += 7;
    if (wa.size() != NE) begin errors++; $display("FAIL load_count: got %0d want %0d", wa.size(), NE); end
    for (int i = 0; i < wa.size(); i++) begin
      checks += 2;
      if (wa[i] !== 5'(i)) begin errors++; $display("FAIL load_addr[%0d]: got %0d want %0d", i, wa[i], i); end
      if (wd[i] !== 16'h3F80 + 16'(i)) begin errors++; $display("FAIL load_data[%0d]: got %0h want %0h", i, wd[i], 16'h3F80 + 16'(i)); end
    end
    if (wa.size() == NE && wc[NE-1] - wc[0] != NE - 1) begin
      errors++; $display("FAIL load_consec: got span %0d want %0d", wc[NE-1] - wc[0], NE - 1);
    end
    if (n_svld != 1) begin errors++; $display("FAIL load_svld_cnt: got %0d want 1", n_svld); end
    if (svld_val !== -5'sd3) begin errors++; $display("FAIL load_scale: got %0d want -3", svld_val); end
    if (n_done != 1) begin errors++; $display("FAIL load_done: got %0d want 1", n_done); end
    if (lut_ready !== 1'b1) begin errors++; $display("FAIL load_ready: got %0b want 1", lut_ready); end
    if (in_rdy !== 1'b1) begin errors++; $display("FAIL load_in_rdy: got %0b want 1", in_rdy); end
  endtask

  task automatic test_drain();
    int last_vld = -1;
    int rise = -1;
    bit leak = 0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      in_vld = 8'hFF;
      cfg_start = (c == 3);
      if (c == 3) cfg_scale_pos = 5'sd6;
      @(negedge clk);
      if (c == 2) begin
        checks++;
        if (dp_in_vld !== 8'hFF) begin errors++; $display("FAIL run_dp_vld: got %0h want ff", dp_in_vld); end
      end
      if (c == 4) begin
        checks += 2;
        if (dp_in_vld !== 8'h00) begin errors++; $display("FAIL drain_dp_vld: got %0h want 0", dp_in_vld); end
        if (cfg_busy !== 1'b1) begin errors++; $display("FAIL drain_busy: got %0b want 1", cfg_busy); end
      end
      if (dp_in_vld != '0) last_vld = cycle;
      if (c >= 4 && dp_in_vld != '0) leak = 1;
      if (cfg_data_rdy) begin
        rise = cycle;
        break;
      end
    end
    cfg_start = 1'b0;
    in_vld = '0;
    checks += 2;
    if (leak) begin errors++; $display("FAIL drain_leak: got 1 want 0"); end
    // Counter re-arms on the last live cycle, counts PL down, then one
    // more cycle for the zero to steer the FSM into LOAD.
    if (rise - last_vld != PL + 2) begin
      errors++; $display("FAIL drain_latency: got %0d want %0d", rise - last_vld, PL + 2);
    end
  endtask

  task automatic test_toggle();
    stream(1'b0, 5'sd0, 1'b1, -1, -1, 5'sd0, NE, 300);
    checks += 3;
    if (wa.size() != NE) begin errors++; $display("FAIL tog_count: got %0d want %0d", wa.size(), NE); end
    for (int i = 0; i < wa.size(); i++) begin
      checks += 2;
      if (wa[i] !== 5'(i)) begin errors++; $display("FAIL tog_addr[%0d]: got %0d want %0d", i, wa[i], i); end
      if (wd[i] !== 16'h3F80 + 16'(i)) begin errors++; $display("FAIL tog_data[%0d]: got %0h want %0h", i, wd[i], 16'h3F80 + 16'(i)); end
      if (i > 0) begin
        checks++;
        if (wc[i] - wc[i-1] != 2) begin errors++; $display("FAIL tog_gap[%0d]: got %0d want 2", i, wc[i] - wc[i-1]); end
      end
    end
    if (svld_val !== 5'sd6) begin errors++; $display("FAIL tog_scale: got %0d want 6", svld_val); end
    if (n_done != 1) begin errors++; $display("FAIL tog_done: got %0d want 1", n_done); end
  endtask

  task automatic test_abort();
    stream(1'b1, 5'sd2, 1'b0, 10, -1, 5'sd0, NE, 100);
    checks += 9;
    if (!aborted) begin errors++; $display("FAIL abort_fired: got 0 want 1"); end
    if (wa.size() != 10) begin errors++; $display("FAIL abort_count: got %0d want 10", wa.size()); end
    if (wa.size() > 0 && wa[wa.size()-1] !== 5'd9) begin
      errors++; $display("FAIL abort_last: got %0d want 9", wa[wa.size()-1]);
    end
    if (cfg_busy !== 1'b0) begin errors++; $display("FAIL abort_busy: got %0b want 0", cfg_busy); end
    if (lut_ready !== 1'b0) begin errors++; $display("FAIL abort_ready: got %0b want 0", lut_ready); end
    if (in_rdy !== 1'b0) begin errors++; $display("FAIL abort_in_rdy: got %0b want 0", in_rdy); end
    if (cfg_data_rdy !== 1'b0) begin errors++; $display("FAIL abort_data_rdy: got %0b want 0", cfg_data_rdy); end
    if (n_svld != 0) begin errors++; $display("FAIL abort_svld: got %0d want 0", n_svld); end
    if (n_done != 0) begin errors++; $display("FAIL abort_done: got %0d want 0", n_done); end
  endtask

  task automatic test_rst_mid_load();
    stream(1'b1, 5'sd4, 1'b0, -1, -1, 5'sd0, 20, 30);
    checks += 3;
    if (wa.size() != 20) begin errors++; $display("FAIL mid_count: got %0d want 20", wa.size()); end
    if (cfg_data_rdy !== 1'b1) begin errors++; $display("FAIL mid_loading: got %0b want 1", cfg_data_rdy); end
    if (lut_waddr !== 5'd19) begin errors++; $display("FAIL mid_waddr: got %0d want 19", lut_waddr); end
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(negedge clk);
    checks += 8;
    if (cfg_busy !== 1'b0) begin errors++; $display("FAIL mrst_busy: got %0b want 0", cfg_busy); end
    if (cfg_data_rdy !== 1'b0) begin errors++; $display("FAIL mrst_data_rdy: got %0b want 0", cfg_data_rdy); end
    if (lut_ready !== 1'b0) begin errors++; $display("FAIL mrst_ready: got %0b want 0", lut_ready); end
    if (lut_wen !== 1'b0) begin errors++; $display("FAIL mrst_wen: got %0b want 0", lut_wen); end
    if (lut_waddr !== '0) begin errors++; $display("FAIL mrst_waddr: got %0h want 0", lut_waddr); end
    if (lut_wdata !== '0) begin errors++; $display("FAIL mrst_wdata: got %0h want 0", lut_wdata); end
    if (out_scale_pos !== '0) begin errors++; $display("FAIL mrst_scale: got %0d want 0", out_scale_pos); end
    if (out_scale_pos_vld !== 1'b0) begin errors++; $display("FAIL mrst_svld: got %0b want 0", out_scale_pos_vld); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (cfg_data_rdy !== 1'b0) begin errors++; $display("FAIL mrst_no_resume: got %0b want 0", cfg_data_rdy); end
    stream(1'b1, 5'sd4, 1'b0, -1, -1, 5'sd0, NE, 200);
    checks += 4;
    if (wa.size() != NE) begin errors++; $display("FAIL reload_count: got %0d want %0d", wa.size(), NE); end
    if (wa.size() > 0 && wa[0] !== 5'd0) begin errors++; $display("FAIL reload_first: got %0d want 0", wa[0]); end
    if (svld_val !== 5'sd4) begin errors++; $display("FAIL reload_scale: got %0d want 4", svld_val); end
    if (n_done != 1) begin errors++; $display("FAIL reload_done: got %0d want 1", n_done); end
  endtask

  task automatic test_start_in_load();
    stream(1'b1, 5'sd3, 1'b0, -1, 5, -5'sd8, NE, 200);
    checks += 4;
    if (wa.size() != NE) begin errors++; $display("FAIL restart_count: got %0d want %0d", wa.size(), NE); end
    if (wa.size() == NE && wa[NE-1] !== 5'd31) begin errors++; $display("FAIL restart_last: got %0d want 31", wa[NE-1]); end
    if (n_svld != 1) begin errors++; $display("FAIL restart_svld: got %0d want 1", n_svld); end
    if (svld_val !== 5'sd3) begin errors++; $display("FAIL restart_scale: got %0d want 3", svld_val); end
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    cfg_start = 1'b0;
    cfg_abort = 1'b0;
    cfg_scale_pos = '0;
    cfg_data = '0;
    cfg_data_vld = 1'b0;
    in_vld = '0;
    test_reset();
    test_load();
    test_drain();
    test_toggle();
    test_abort();
    test_rst_mid_load();
    test_start_in_load();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
